// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 mode constants and axis helpers
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Positions per axis (pixels per line or lines per frame).
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..total-1, never narrower than one bit.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from generator to pixel consumer
interface vga_timing_gen_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 9
);
    logic             pixelEn;
    logic             hSync;
    logic             vSync;
    logic [COL_W-1:0] column;
    logic [ROW_W-1:0] row;
    logic             displayActive;
    logic             lineStart;
    logic             frameStart;
    logic             vBlank;

    modport master (
        output pixelEn, hSync, vSync, column, row,
        output displayActive, lineStart, frameStart, vBlank
    );

    modport slave (
        input pixelEn, hSync, vSync, column, row,
        input displayActive, lineStart, frameStart, vBlank
    );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with active/sync decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = SYNC_ACTIVE_LOW,
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int CW    = cnt_width(TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    logic sync_on;

    // Step the position on each enable, returning to 0 after the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

    assign wrap    = (count == CW'(TOTAL - 1));
    assign active  = (count < CW'(ACTIVE));
    // Upper bound written inclusively so a zero back porch cannot overflow CW.
    assign sync_on = (count >= CW'(ACTIVE + FP)) && (count <= CW'(ACTIVE + FP + SYNC - 1));
    assign sync    = sync_on ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator top
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int COL_W      = $clog2(H_ACTIVE),
    parameter int ROW_W      = $clog2(V_ACTIVE)
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int H_CW  = cnt_width(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int V_CW  = cnt_width(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int DIV_W = cnt_width(CLK_DIV);

    logic [DIV_W-1:0] div_count;
    logic             tick;
    logic [H_CW-1:0]  h_count;
    logic [V_CW-1:0]  v_count;
    logic             h_wrap, h_active, h_sync;
    logic             v_wrap_unused, v_active, v_sync;

    // tick marks the last system clock of the current pixel; counters advance on it.
    assign tick = (div_count == DIV_W'(CLK_DIV - 1));

    // Pixel clock divider; with CLK_DIV=1 it sits at 0 and tick stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_count <= '0;
        end else begin
            div_count <= tick ? '0 : div_count + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .inc    (tick),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    // Vertical steps on the same edge the horizontal counter wraps.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .inc    (tick & h_wrap),
        .count  (v_count),
        .wrap   (v_wrap_unused),
        .active (v_active),
        .sync   (v_sync)
    );

    // Register the decode of the current position; strobes fire once, on the pixel's tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.pixelEn       <= 1'b0;
            vga.hSync         <= ~H_SYNC_POL;
            vga.vSync         <= ~V_SYNC_POL;
            vga.column        <= '0;
            vga.row           <= '0;
            vga.displayActive <= 1'b0;
            vga.lineStart     <= 1'b0;
            vga.frameStart    <= 1'b0;
            vga.vBlank        <= 1'b0;
        end else begin
            vga.pixelEn       <= tick;
            vga.hSync         <= h_sync;
            vga.vSync         <= v_sync;
            vga.column        <= h_active ? h_count[COL_W-1:0] : '0;
            vga.row           <= v_active ? v_count[ROW_W-1:0] : '0;
            vga.displayActive <= h_active & v_active;
            vga.lineStart     <= tick && (h_count == '0);
            vga.frameStart    <= tick && (h_count == '0) && (v_count == '0);
            vga.vBlank        <= ~v_active;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen in three modes
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    typedef struct packed {
        logic        pix, hs, vs, da, ls, fs, vb;
        logic [15:0] col, row;
    } exp_t;

    typedef struct {
        int div, ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hpol, vpol;
    } mode_t;

    int    errors = 0;
    int    checks = 0;
    exp_t  sb[$];
    mode_t m_def, m_small, m_tiny;

    vga_timing_gen_if #(.COL_W(10), .ROW_W(9)) vif_def ();
    vga_timing_gen_if #(.COL_W(3),  .ROW_W(3)) vif_small ();
    vga_timing_gen_if #(.COL_W(2),  .ROW_W(2)) vif_tiny ();

    vga_timing_gen dut_def (.clk(clk), .rst(rst), .vga(vif_def));

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COL_W(3), .ROW_W(3)
    ) dut_small (.clk(clk), .rst(rst), .vga(vif_small));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .COL_W(2), .ROW_W(2)
    ) dut_tiny (.clk(clk), .rst(rst), .vga(vif_tiny));

    // Expected outputs k clocks after reset release (k=0: reset state).
    function automatic exp_t model(input mode_t m, input int k);
        exp_t e;
        int ht, vt, p, ph, h, v;
        e = '0;
        if (k == 0) begin
            e.hs = ~m.hpol;
            e.vs = ~m.vpol;
            return e;
        end
        ht = m.ha + m.hfp + m.hs + m.hbp;
        vt = m.va + m.vfp + m.vs + m.vbp;
        p  = (k - 1) / m.div;
        ph = (k - 1) % m.div;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.pix = (ph == m.div - 1);
        e.hs  = (h >= m.ha + m.hfp && h < m.ha + m.hfp + m.hs) ? m.hpol : ~m.hpol;
        e.vs  = (v >= m.va + m.vfp && v < m.va + m.vfp + m.vs) ? m.vpol : ~m.vpol;
        e.da  = (h < m.ha) && (v < m.va);
        e.col = (h < m.ha) ? 16'(h) : 16'd0;
        e.row = (v < m.va) ? 16'(v) : 16'd0;
        e.ls  = e.pix && (h == 0);
        e.fs  = e.pix && (h == 0) && (v == 0);
        e.vb  = (v >= m.va);
        return e;
    endfunction

    function automatic exp_t obs_def();
        exp_t o;
        o.pix = vif_def.pixelEn;   o.hs = vif_def.hSync;      o.vs = vif_def.vSync;
        o.da  = vif_def.displayActive; o.ls = vif_def.lineStart; o.fs = vif_def.frameStart;
        o.vb  = vif_def.vBlank;    o.col = 16'(vif_def.column); o.row = 16'(vif_def.row);
        return o;
    endfunction

    function automatic exp_t obs_small();
        exp_t o;
        o.pix = vif_small.pixelEn; o.hs = vif_small.hSync;    o.vs = vif_small.vSync;
        o.da  = vif_small.displayActive; o.ls = vif_small.lineStart; o.fs = vif_small.frameStart;
        o.vb  = vif_small.vBlank;  o.col = 16'(vif_small.column); o.row = 16'(vif_small.row);
        return o;
    endfunction

    function automatic exp_t obs_tiny();
        exp_t o;
        o.pix = vif_tiny.pixelEn;  o.hs = vif_tiny.hSync;     o.vs = vif_tiny.vSync;
        o.da  = vif_tiny.displayActive; o.ls = vif_tiny.lineStart; o.fs = vif_tiny.frameStart;
        o.vb  = vif_tiny.vBlank;   o.col = 16'(vif_tiny.column); o.row = 16'(vif_tiny.row);
        return o;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_def() !== model(m_def, 0)) begin
            errors++; $display("FAIL reset_def got=%h exp=%h", obs_def(), model(m_def, 0));
        end
        checks++;
        if (obs_small() !== model(m_small, 0)) begin
            errors++; $display("FAIL reset_small got=%h exp=%h", obs_small(), model(m_small, 0));
        end
        checks++;
        if (obs_tiny() !== model(m_tiny, 0)) begin
            errors++; $display("FAIL reset_tiny got=%h exp=%h", obs_tiny(), model(m_tiny, 0));
        end
    endtask

    task automatic test_default_hsync();
        exp_t e, o;
        time  t_e1, t_edge, f0, r0, f1;
        time  ed[$];
        logic prev;
        int   da_line0;
        da_line0 = 0;
        t_e1 = 0;
        do_reset();
        prev = model(m_def, 0).hs;
        for (int k = 1; k <= 4800; k++) begin
            @(posedge clk);
            t_edge = $time;
            if (k == 1) t_e1 = t_edge;
            sb.push_back(model(m_def, k));
            @(negedge clk);
            e = sb.pop_front();
            o = obs_def();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL def_cycle k=%0d got=%h exp=%h", k, o, e);
            end
            if (o.hs !== prev) ed.push_back(t_edge - t_e1);
            prev = o.hs;
            if (k <= 1600 && o.da === 1'b1) da_line0++;
        end
        f0 = (ed.size() > 0) ? ed[0] : 0;
        r0 = (ed.size() > 1) ? ed[1] : 0;
        f1 = (ed.size() > 2) ? ed[2] : 0;
        checks++;
        if (ed.size() != 6) begin
            errors++; $display("FAIL def_hsync_edges got=%0d exp=6", ed.size());
        end
        checks++;
        if (f0 != 26240) begin
            errors++; $display("FAIL def_hsync_fall got=%0t exp=26240", f0);
        end
        checks++;
        if (r0 - f0 != 3840) begin
            errors++; $display("FAIL def_hsync_width got=%0t exp=3840", r0 - f0);
        end
        checks++;
        if (f1 - f0 != 32000) begin
            errors++; $display("FAIL def_hsync_period got=%0t exp=32000", f1 - f0);
        end
        checks++;
        if (da_line0 != 1280) begin
            errors++; $display("FAIL def_active_clks got=%0d exp=1280", da_line0);
        end
    endtask

    task automatic test_small_frame();
        exp_t e, o;
        time  t_e1, t_edge, f0, r0, f1;
        time  ed[$];
        logic prev, prev_fs, prev_ls;
        int   fs_cnt, ls_cnt, wide, vb_cnt;
        fs_cnt = 0; ls_cnt = 0; wide = 0; vb_cnt = 0; t_e1 = 0;
        do_reset();
        prev = model(m_small, 0).vs;
        prev_fs = 1'b0; prev_ls = 1'b0;
        for (int k = 1; k <= 720; k++) begin
            @(posedge clk);
            t_edge = $time;
            if (k == 1) t_e1 = t_edge;
            sb.push_back(model(m_small, k));
            @(negedge clk);
            e = sb.pop_front();
            o = obs_small();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL small_cycle k=%0d got=%h exp=%h", k, o, e);
            end
            if (o.vs !== prev) ed.push_back(t_edge - t_e1);
            prev = o.vs;
            if (o.fs === 1'b1) fs_cnt++;
            if (o.ls === 1'b1) ls_cnt++;
            if ((o.fs === 1'b1 && prev_fs) || (o.ls === 1'b1 && prev_ls)) wide++;
            prev_fs = (o.fs === 1'b1);
            prev_ls = (o.ls === 1'b1);
            if (k <= 360 && o.vb === 1'b1) vb_cnt++;
            if (k == 151) begin
                checks++;
                if (o.row !== 16'd5 || o.col !== 16'd0 || o.da !== 1'b1) begin
                    errors++; $display("FAIL small_last_line row=%0d col=%0d da=%b exp 5/0/1", o.row, o.col, o.da);
                end
            end
            if (k == 25) begin
                checks++;
                if (o.col !== 16'd0 || o.da !== 1'b0) begin
                    errors++; $display("FAIL small_hblank col=%0d da=%b exp 0/0", o.col, o.da);
                end
            end
        end
        f0 = (ed.size() > 0) ? ed[0] : 0;
        r0 = (ed.size() > 1) ? ed[1] : 0;
        f1 = (ed.size() > 2) ? ed[2] : 0;
        checks++;
        if (ed.size() != 4) begin
            errors++; $display("FAIL small_vsync_edges got=%0d exp=4", ed.size());
        end
        checks++;
        if (f0 != 4800 || r0 - f0 != 1200 || f1 - f0 != 7200) begin
            errors++; $display("FAIL small_vsync_timing fall=%0t width=%0t period=%0t exp 4800/1200/7200", f0, r0 - f0, f1 - f0);
        end
        checks++;
        if (fs_cnt != 2 || ls_cnt != 24) begin
            errors++; $display("FAIL small_strobe_counts fs=%0d ls=%0d exp 2/24", fs_cnt, ls_cnt);
        end
        checks++;
        if (wide != 0) begin
            errors++; $display("FAIL small_strobe_width wide=%0d exp=0", wide);
        end
        checks++;
        if (vb_cnt != 180) begin
            errors++; $display("FAIL small_vblank_clks got=%0d exp=180", vb_cnt);
        end
    endtask

    task automatic test_tiny();
        exp_t e, o;
        int   fs_cnt, hs_cnt, ls_cnt;
        fs_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            sb.push_back(model(m_tiny, k));
            @(negedge clk);
            e = sb.pop_front();
            o = obs_tiny();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL tiny_cycle k=%0d got=%h exp=%h", k, o, e);
            end
            if (k <= 96 && o.fs === 1'b1) fs_cnt++;
            if (k <= 48 && o.ls === 1'b1) ls_cnt++;
            if (k <= 8 && o.hs === 1'b1) hs_cnt++;
            if (k == 6) begin
                checks++;
                if (o.hs !== 1'b1) begin
                    errors++; $display("FAIL tiny_hsync_h5 got=%b exp=1", o.hs);
                end
            end
            if (k == 49) begin
                checks++;
                if (o.fs !== 1'b1) begin
                    errors++; $display("FAIL tiny_second_frame got=%b exp=1", o.fs);
                end
            end
        end
        checks++;
        if (fs_cnt != 2 || ls_cnt != 6 || hs_cnt != 2) begin
            errors++; $display("FAIL tiny_counts fs=%0d ls=%0d hs=%0d exp 2/6/2", fs_cnt, ls_cnt, hs_cnt);
        end
    endtask

    task automatic test_reset_mid_hsync();
        exp_t e, o;
        time  t_e1, t_edge;
        time  ed[$];
        logic prev;
        t_e1 = 0;
        do_reset();
        for (int k = 1; k <= 143; k++) begin
            @(posedge clk);
            sb.push_back(model(m_small, k));
            @(negedge clk);
            e = sb.pop_front();
            o = obs_small();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL mid_pre k=%0d got=%h exp=%h", k, o, e);
            end
        end
        checks++;
        if (obs_small().hs !== 1'b0) begin
            errors++; $display("FAIL mid_in_hsync got=%b exp=0", obs_small().hs);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_small() !== model(m_small, 0)) begin
            errors++; $display("FAIL mid_reset_state got=%h exp=%h", obs_small(), model(m_small, 0));
        end
        do_reset();
        prev = model(m_small, 0).hs;
        for (int k = 1; k <= 360; k++) begin
            @(posedge clk);
            t_edge = $time;
            if (k == 1) t_e1 = t_edge;
            sb.push_back(model(m_small, k));
            @(negedge clk);
            e = sb.pop_front();
            o = obs_small();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL mid_post k=%0d got=%h exp=%h", k, o, e);
            end
            if (o.hs !== prev) ed.push_back(t_edge - t_e1);
            prev = o.hs;
        end
        checks++;
        if (ed.size() != 24 || ((ed.size() > 0) ? ed[0] : 0) != 400) begin
            errors++; $display("FAIL mid_restart_hsync edges=%0d first=%0t exp 24/400", ed.size(), (ed.size() > 0) ? ed[0] : 0);
        end
    endtask

    initial begin
        m_def   = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        m_small = '{2, 8, 2, 3, 2, 6, 2, 2, 2, 1'b0, 1'b0};
        m_tiny  = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0};
        test_reset();
        test_default_hsync();
        test_small_frame();
        test_tiny();
        test_reset_mid_hsync();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
